// File: rtl/kernel_result_writer.sv
// Clamps 3x3 kernel results to pixels (with emboss bias), buffers them in a small show-ahead FIFO
// and writes them in raster order to the output frame RAM, flagging frame completion and overflow.
module kernel_result_writer #(
  parameter int unsigned IMG_W       = 256,
  parameter int unsigned IMG_H       = 256,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 17,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned EMBOSS_BIAS = 128
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [1:0]                    mode,
  input  logic                          result,
  input  logic [DATA_W-1:0]             output_result,
  input  logic                          frame_start,
  input  logic                          wr_ready,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [PIX_W-1:0]              wr_data,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned VW   = DATA_W + 1;

  localparam logic signed [VW-1:0] Bias     = VW'(EMBOSS_BIAS);
  localparam logic signed [VW-1:0] PixMax   = VW'((2 ** PIX_W) - 1);
  localparam logic [CntW-1:0]      Depth    = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]    LastAddr = ADDR_W'(IMG_W * IMG_H - 1);

  logic                 s1_valid_q;
  logic [PIX_W-1:0]     s1_pix_q;
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [ADDR_W-1:0]    addr_q;
  logic                 frame_done_q;
  logic                 overflow_q;
  logic [PIX_W-1:0]     mem [FIFO_DEPTH];

  logic signed [VW-1:0] v;
  logic [PIX_W-1:0]     pix_c;
  logic                 push, pop, drop;

  // One extra bit of headroom so the bias can never wrap a large positive result.
  always_comb begin
    v = $signed({output_result[DATA_W-1], output_result});
    if (mode == 2'b11) begin
      v = v + Bias;
    end
    if (v[VW-1]) begin
      pix_c = '0;
    end else if (v > PixMax) begin
      pix_c = '1;
    end else begin
      pix_c = v[PIX_W-1:0];
    end
  end

  // frame_start overrides any push or pop in the same cycle.
  always_comb begin
    pop  = (count_q != '0) && wr_ready && !frame_start;
    push = s1_valid_q && ((count_q < Depth) || pop) && !frame_start;
    drop = s1_valid_q && !push && !frame_start;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s1_pix_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid_q   <= 1'b0;
      s1_pix_q     <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else if (frame_start) begin
      s1_valid_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      s1_valid_q <= result;
      if (result) begin
        s1_pix_q <= pix_c;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
      end
      count_q      <= count_d;
      frame_done_q <= pop && (addr_q == LastAddr);
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Show-ahead head; gated so an empty FIFO presents zero rather than stale storage.
  assign wr_en      = (count_q != '0);
  assign wr_data    = wr_en ? mem[rd_ptr_q] : '0;
  assign wr_addr    = addr_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: doc/kernel_result_writer.md
Name: kernel_result_writer

Overview:
- Downstream stage of the 3x3 kernel operator (blur/sharpen/outline/emboss). It consumes the operator's 17-bit signed result and its one-cycle result strobe, and applies the emboss bias.
- It clamps each result to an 8-bit pixel and buffers it in a small FIFO. It then writes the pixel in raster order into the 256x256 output frame RAM through a ready-gated write port.
- Frame completion and overflow are flagged for the pipeline controller.

Parameters:
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in pixels
- ADDR_W, 16, output RAM address width (log2(IMG_W*IMG_H))
- DATA_W, 17, kernel result width (two's complement)
- PIX_W, 8, output pixel width
- FIFO_DEPTH, 4, buffer entries (power of two, >=2)
- EMBOSS_BIAS, 128, offset added in emboss mode before clamping

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- mode  in  2  00 blur, 01 sharpen, 10 outline, 11 emboss; sampled with each accepted result
- result  in  1  one-cycle strobe: output_result valid
- output_result  in  DATA_W  signed kernel result
- frame_start  in  1  synchronous clear of address counter, FIFO, stage-1 valid, overflow
- wr_ready  in  1  output RAM accepts a write this cycle
- wr_en  out  1  write request (FIFO non-empty)
- wr_addr  out  ADDR_W  raster address of head pixel
- wr_data  out  PIX_W  clamped pixel at FIFO head
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- overflow  out  1  sticky: a result was dropped
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (n_rst low, async): wr_en=0, wr_addr=0, wr_data=0, frame_done=0, overflow=0, fifo_count=0; stage-1 valid cleared. Reset mid-frame discards all buffered pixels.
- Stage 1, registered, 1 cycle:
  - On result=1, compute v = output_result sign-extended to DATA_W+1 bits, plus EMBOSS_BIAS if mode==11, else plus 0.
  - Clamp: v<0 gives 0; v>2^PIX_W-1 gives 255; otherwise v[7:0].
  - Register the pixel with s1_valid=1; s1_valid=0 when result=0.
- FIFO push:
  - When s1_valid=1, push if fifo_count<FIFO_DEPTH, or if a pop occurs the same cycle.
  - Otherwise drop the pixel and set overflow=1 (sticky until frame_start or reset). A dropped pixel does not advance the address.
- FIFO head is show-ahead: wr_en = (fifo_count!=0); wr_data = head entry, with no extra register.
- Pop and write: a write completes in any cycle with wr_en && wr_ready.
  - On completion, pop the FIFO and increment wr_addr.
  - At address IMG_W*IMG_H-1 the address wraps to 0 and frame_done pulses high for the following cycle.
- wr_addr holds and wr_data is stable while wr_en=1 and wr_ready=0.
- Latency: result at cycle N with an empty FIFO and wr_ready=1 gives wr_en=1 with that pixel in cycle N+2; it is written at the end of N+2.
- Throughput: one pixel per cycle sustained when wr_ready=1.
- Simultaneous push and pop: fifo_count unchanged. Full FIFO plus pop plus push: accepted, no overflow.
- frame_start:
  - Has priority over push and pop in the same cycle.
  - Sets wr_addr=0, fifo_count=0, s1_valid=0, overflow=0, and no frame_done pulse.
  - A result strobe in the same cycle is discarded.
- Arithmetic is performed in DATA_W+1 bits so that the bias cannot wrap.
- The block never alters mode semantics beyond the bias.

Test Plan:
- Clamp, blur mode, wr_ready=1, results -5, 0, 200, 300 (17-bit two's complement) -> wr_data 0, 0, 200, 255 at wr_addr 0..3. First wr_en appears 2 cycles after the first strobe.
- Emboss bias, mode=11, results -128, -129, 0, 127, 200 -> wr_data 0, 0, 128, 255, 255.
- Backpressure: wr_ready=0, 6 consecutive strobes (values 1..6) -> fifo_count reaches 4 and overflow=1. After wr_ready=1, exactly 1, 2, 3, 4 are written at addresses 0..3, and wr_data/wr_addr hold steady while stalled.
- Full plus simultaneous pop: FIFO full, wr_ready=1 with continuous strobes -> no overflow, one write per cycle, fifo_count stays 4.
- Frame wrap: stream 65536 strobes with wr_ready=1 -> the last write is at wr_addr 65535, frame_done pulses exactly once in the next cycle, wr_addr returns to 0, and a 65537th strobe is written at address 0.
- Reset and frame_start mid-stream:
  - Assert n_rst=0 asynchronously with 3 entries buffered -> all outputs return to reset values immediately.
  - frame_start in the same cycle as a strobe and a write -> count 0, address 0, strobe dropped, overflow cleared.
